mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares a single-port unified instruction/data memory between the pipeline's fetch stage (I-side) and memory stage (D-side). It grants one transaction at a time and drives the memory request/acknowledge handshake. Per-side acknowledges let the core derive StallF/StallM. It also absorbs fetch cancellation on branch mispredict (BTA_MP | Branch_MP) without corrupting the memory handshake.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_D_STREAK, 4, max consecutive D grants while I is pending before I is forced (≥1)

- CLK  in  1  clock; all state updates on rising edge
- Reset  in  1  reset, synchronous, active-low
- I_req  in  1  fetch request; held until I_ack or I_cancel
- I_addr  in  AW  fetch address; stable while I_req
- I_cancel  in  1  mispredict flush; kills the pending or in-flight fetch
- I_ack  out  1  fetch complete; I_rdata valid this cycle
- I_rdata  out  DW  fetch data
- D_req  in  1  load/store request; held until D_ack
- D_we  in  1  1 = store
- D_addr  in  AW  data address
- D_wdata  in  DW  store data
- D_ack  out  1  data access complete; D_rdata valid for loads
- D_rdata  out  DW  load data
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ack  in  1  memory completion; one cycle per request; may come in the first mem_req cycle
- mem_rdata  in  DW  read data, valid with mem_ack
- busy  out  1  state != IDLE

## Operation
- States: IDLE, BUSY_I, BUSY_D, DROP_I.
- IDLE, grant selection:
  - Candidates are I (I_req & ~I_cancel) and D (D_req).
  - D wins by default because it is the older instruction.
  - I wins if only I is a candidate, or if both are and streak == MAX_D_STREAK.
- On grant, latch mem_addr, mem_we (0 for I, D_we for D) and mem_wdata (D_wdata, or 0 for I). Next state is BUSY_I or BUSY_D.
- streak counter (width clog2(MAX_D_STREAK+1), saturating):
  - On a D grant with I_req & ~I_cancel high: +1.
  - On a D grant with I idle: cleared.
  - On an I grant: cleared.
- BUSY_I:
  - mem_req=1.
  - mem_ack & ~I_cancel: I_ack=1, I_rdata=mem_rdata, go to IDLE.
  - mem_ack & I_cancel: no I_ack, go to IDLE.
  - ~mem_ack & I_cancel: go to DROP_I.
- DROP_I:
  - mem_req stays 1 with unchanged address. The memory cannot abort.
  - On mem_ack, discard data, emit no I_ack, go to IDLE.
  - Further I_cancel pulses are ignored.
- BUSY_D:
  - mem_req=1.
  - On mem_ack: D_ack=1, D_rdata=mem_rdata (don't-care for stores), go to IDLE.
  - I_cancel has no effect.
- I_ack and D_ack are combinational from mem_ack and state. They are never both high, and never high in IDLE or DROP_I.
- mem_addr, mem_we and mem_wdata are stable from grant until the mem_ack cycle inclusive.
- Reset (Reset=0 at an edge) gives:
  - state IDLE, streak 0
  - mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0
  - I_ack 0, D_ack 0, I_rdata 0, D_rdata 0, busy 0
- Reset mid-transaction abandons the transaction with no ack. The memory model is reset in the same cycle.

## Timing
- Request sampled in IDLE at edge t: mem_req high from t+1.
- Earliest completion: mem_ack in cycle t+1, X_ack in cycle t+1, IDLE at t+2.
- Minimum service period is 2 cycles per transaction. There are no back-to-back grants without an IDLE cycle.
- Requester samples X_ack at the edge that returns the arbiter to IDLE. It must drop or replace its request in the following cycle.
- Latency seen by a requester = 1 + memory wait cycles + any wait for the other side's in-flight transaction.
- I_cancel is level-sampled at each edge in IDLE and BUSY_I only.

## Test plan
- **Single fetch, zero-wait memory:** I_req=1, I_addr=0x40 at cycle 0; mem_ack in cycle 1 with rdata=0xE3A01005 → mem_req=1 and mem_addr=0x40 in cycle 1, I_ack=1 and I_rdata=0xE3A01005 in cycle 1, busy=0 in cycle 2.
- **Simultaneous requests, D priority then starvation guard (MAX_D_STREAK=4):**
  - I_req and D_req both held; memory acks each request after 2 cycles.
  - Required: exactly 4 D grants, then 1 I grant, then D again.
  - Streak reads 4 at the I grant and 0 after it.
- **Store:** D_req=1, D_we=1, D_addr=0x100, D_wdata=0xDEADBEEF → mem_we=1 and mem_wdata=0xDEADBEEF held for 3 wait cycles until mem_ack; D_ack=1 in the ack cycle only.
- **Mispredict during fetch:**
  - BUSY_I with 3 wait cycles; I_cancel pulses in the 1st wait cycle.
  - Required: state DROP_I, mem_req and mem_addr unchanged until mem_ack, I_ack never asserted, IDLE the next cycle.
  - A D_req pending throughout is granted in that IDLE cycle.
- **Cancel coincident with ack:** I_cancel=1 in the same cycle as mem_ack in BUSY_I → I_ack=0 and return to IDLE. Separately, in IDLE, I_req=1 with I_cancel=1 → no I grant.
- **Reset mid-operation:** Reset=0 during BUSY_D wait → next cycle mem_req=0, D_ack=0, busy=0, streak=0. After release, a new I_req is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port unified memory between the fetch stage (I-side)
// and the memory stage (D-side). One transaction is in flight at a time.
// D wins a simultaneous request because it belongs to the older
// instruction. After MAX_D_STREAK consecutive D grants taken while a fetch
// was waiting, the fetch is forced through so the front end cannot starve.
// A fetch cancelled after its memory request has gone out is parked in
// DROP_I until the memory answers, because the memory cannot abort.
//
// Handshakes:
//   I_req / D_req are held by the requester until the matching ack (or,
//   for I, until I_cancel). mem_req is held with stable mem_addr / mem_we /
//   mem_wdata until the cycle mem_ack is high; mem_ack may arrive in the
//   first mem_req cycle. A requester samples its ack at the edge that
//   returns the arbiter to IDLE, so every grant is separated by one IDLE cycle.
//
// Ports:
//   CLK, Reset          clock, synchronous active-low reset
//   I_req/I_addr        fetch request and address
//   I_cancel            mispredict flush of the pending or in-flight fetch
//   I_ack/I_rdata       fetch completion and data (data is 0 when no ack)
//   D_req/D_we/D_addr/D_wdata  load/store request
//   D_ack/D_rdata       data completion and load data (0 when no ack)
//   mem_req/mem_we/mem_addr/mem_wdata  memory request side
//   mem_ack/mem_rdata   memory completion and read data
//   busy                arbiter not in IDLE
//   state_dbg           FSM state: 0 IDLE, 1 BUSY_I, 2 BUSY_D, 3 DROP_I
//   streak_dbg          current count of D grants taken while I waited

module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                                  CLK,
    input  logic                                  Reset,
    input  logic                                  I_req,
    input  logic [AW-1:0]                         I_addr,
    input  logic                                  I_cancel,
    output logic                                  I_ack,
    output logic [DW-1:0]                         I_rdata,
    input  logic                                  D_req,
    input  logic                                  D_we,
    input  logic [AW-1:0]                         D_addr,
    input  logic [DW-1:0]                         D_wdata,
    output logic                                  D_ack,
    output logic [DW-1:0]                         D_rdata,
    output logic                                  mem_req,
    output logic                                  mem_we,
    output logic [AW-1:0]                         mem_addr,
    output logic [DW-1:0]                         mem_wdata,
    input  logic                                  mem_ack,
    input  logic [DW-1:0]                         mem_rdata,
    output logic                                  busy,
    output logic [1:0]                            state_dbg,
    output logic [$clog2(MAX_D_STREAK+1)-1:0]     streak_dbg
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DROP_I = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   streak, streak_nxt;
    logic [AW-1:0]   addr_q, addr_nxt;
    logic            we_q, we_nxt;
    logic [DW-1:0]   wdata_q, wdata_nxt;

    // A cancelled fetch is not a candidate even if I_req is still high.
    logic i_cand;
    logic grant_i;

    assign i_cand  = I_req & ~I_cancel;
    assign grant_i = i_cand & (~D_req | (streak == STREAK_MAX));

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state   <= IDLE;
            streak  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state   <= state_nxt;
            streak  <= streak_nxt;
            addr_q  <= addr_nxt;
            we_q    <= we_nxt;
            wdata_q <= wdata_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        addr_nxt   = addr_q;
        we_nxt     = we_q;
        wdata_nxt  = wdata_q;
        I_ack      = 1'b0;
        D_ack      = 1'b0;

        case (state)
            IDLE: begin
                if (grant_i) begin
                    state_nxt  = BUSY_I;
                    addr_nxt   = I_addr;
                    we_nxt     = 1'b0;
                    wdata_nxt  = '0;
                    streak_nxt = '0;
                end else if (D_req) begin
                    state_nxt  = BUSY_D;
                    addr_nxt   = D_addr;
                    we_nxt     = D_we;
                    wdata_nxt  = D_wdata;
                    // Only D grants that overtook a waiting fetch count.
                    if (i_cand) begin
                        if (streak != STREAK_MAX) begin
                            streak_nxt = streak + SW'(1);
                        end
                    end else begin
                        streak_nxt = '0;
                    end
                end
            end
            BUSY_I: begin
                if (mem_ack) begin
                    I_ack     = ~I_cancel;
                    state_nxt = IDLE;
                end else if (I_cancel) begin
                    state_nxt = DROP_I;
                end
            end
            DROP_I: begin
                // Request stays up until the memory answers; data discarded.
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    D_ack     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign I_rdata    = I_ack ? mem_rdata : '0;
    assign D_rdata    = D_ack ? mem_rdata : '0;
    assign mem_req    = (state != IDLE);
    assign busy       = (state != IDLE);
    assign mem_addr   = addr_q;
    assign mem_we     = we_q;
    assign mem_wdata  = wdata_q;
    assign state_dbg  = state;
    assign streak_dbg = streak;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by a random
// phase, all checked every cycle against a transaction-level reference
// model (owner of the memory, streak count, shadow memory and an expected
// read-data queue).

module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int SW   = $clog2(MAXS + 1);

    // ---------------- clock / reset / DUT ----------------
    logic          CLK = 1'b0;
    logic          Reset = 1'b0;
    logic          I_req = 1'b0;
    logic [AW-1:0] I_addr = '0;
    logic          I_cancel = 1'b0;
    logic          I_ack;
    logic [DW-1:0] I_rdata;
    logic          D_req = 1'b0;
    logic          D_we = 1'b0;
    logic [AW-1:0] D_addr = '0;
    logic [DW-1:0] D_wdata = '0;
    logic          D_ack;
    logic [DW-1:0] D_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic [1:0]    state_dbg;
    logic [SW-1:0] streak_dbg;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS)) dut (
        .CLK(CLK), .Reset(Reset),
        .I_req(I_req), .I_addr(I_addr), .I_cancel(I_cancel),
        .I_ack(I_ack), .I_rdata(I_rdata),
        .D_req(D_req), .D_we(D_we), .D_addr(D_addr), .D_wdata(D_wdata),
        .D_ack(D_ack), .D_rdata(D_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .state_dbg(state_dbg), .streak_dbg(streak_dbg)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] a);
        return int'(a[7:2]);
    endfunction

    // ---------------- memory model ----------------
    logic [31:0] mem_arr [64];
    int          cnt = 0;
    int          mem_wait = 0;
    bit          rand_wait = 1'b0;
    int          n_acks = 0;

    task automatic mem_drive();
        if (!Reset) begin
            mem_ack = 1'b0;
            cnt     = 0;
        end else if (mem_req) begin
            if (cnt >= mem_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_arr[idx(mem_addr)];
                if (mem_we) mem_arr[idx(mem_addr)] = mem_wdata;
                cnt = 0;
                n_acks++;
                if (rand_wait) mem_wait = int'($urandom_range(0, 3));
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                cnt++;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            cnt       = 0;
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // m_owner: 0 nobody, 1 fetch, 2 data. m_killed: fetch owner was cancelled.
    int          m_owner = 0;
    bit          m_killed = 1'b0;
    int          m_streak = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic        m_we = 1'b0;
    logic [31:0] shadow [64];
    logic [31:0] exp_q [$];
    int          grant_log [$];
    int          streak_at_igrant = -1;
    logic        seen_iack = 1'b0;
    logic        seen_dack = 1'b0;
    logic        seen_icancel = 1'b0;

    task automatic model_step();
        logic        e_iack;
        logic        e_dack;
        logic [31:0] e;
        bit          icand;

        chk("busy", 64'(busy), 64'(m_owner != 0));
        chk("mem_req", 64'(mem_req), 64'(m_owner != 0));
        chk("ack_exclusive", 64'(I_ack & D_ack), 64'd0);
        if (m_owner != 0) begin
            chk("mem_addr", 64'(mem_addr), 64'(m_addr));
            chk("mem_we", 64'(mem_we), 64'(m_we));
            chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end
        e_iack = (m_owner == 1) && !m_killed && mem_ack && !I_cancel;
        e_dack = (m_owner == 2) && mem_ack;
        chk("I_ack", 64'(I_ack), 64'(e_iack));
        chk("D_ack", 64'(D_ack), 64'(e_dack));
        chk("streak", 64'(streak_dbg), 64'(m_streak));
        if (m_owner != 0 && mem_ack) begin
            chk("sb_size", 64'(exp_q.size()), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e_iack) chk("I_rdata", 64'(I_rdata), 64'(e));
                if (e_dack && !m_we) chk("D_rdata", 64'(D_rdata), 64'(e));
            end
        end

        seen_iack    = I_ack;
        seen_dack    = D_ack;
        seen_icancel = I_cancel;

        if (!Reset) begin
            m_owner  = 0;
            m_killed = 1'b0;
            m_streak = 0;
            exp_q.delete();
        end else if (m_owner == 0) begin
            icand = I_req && !I_cancel;
            if (icand && (!D_req || m_streak == MAXS)) begin
                streak_at_igrant = int'(streak_dbg);
                m_owner  = 1;
                m_addr   = I_addr;
                m_we     = 1'b0;
                m_wdata  = '0;
                m_streak = 0;
                exp_q.push_back(shadow[idx(I_addr)]);
                grant_log.push_back(1);
            end else if (D_req) begin
                m_owner  = 2;
                m_addr   = D_addr;
                m_we     = D_we;
                m_wdata  = D_wdata;
                m_streak = icand ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
                exp_q.push_back(D_we ? 32'd0 : shadow[idx(D_addr)]);
                grant_log.push_back(2);
            end
        end else if (mem_ack) begin
            if (m_we) shadow[idx(m_addr)] = m_wdata;
            m_owner  = 0;
            m_killed = 1'b0;
        end else if (m_owner == 1 && I_cancel) begin
            m_killed = 1'b1;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are changed just after the rising edge; the memory answers
    // and outputs are checked around the falling edge.
    task automatic clk_start();
        @(posedge CLK);
        #1;
    endtask

    task automatic clk_end();
        @(negedge CLK);
        mem_drive();
        #1;
        model_step();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            clk_start();
            clk_end();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int exp_seq [6] = '{2, 2, 2, 2, 1, 2};
        bit i_pend;
        bit d_pend;

        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = $urandom;
            shadow[i]  = mem_arr[i];
        end
        mem_arr[16] = 32'hE3A01005;
        shadow[16]  = 32'hE3A01005;

        // Reset state
        Reset = 1'b0;
        repeat (2) @(posedge CLK);
        clk_end();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_I_ack", 64'(I_ack), 64'd0);
        chk("rst_D_ack", 64'(D_ack), 64'd0);
        chk("rst_I_rdata", 64'(I_rdata), 64'd0);
        chk("rst_D_rdata", 64'(D_rdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_streak", 64'(streak_dbg), 64'd0);
        clk_start(); Reset = 1'b1; clk_end();

        // Single fetch, zero-wait memory
        clk_start(); mem_wait = 0; I_req = 1'b1; I_addr = 32'h40; clk_end();
        chk("t1_idle_busy", 64'(busy), 64'd0);
        clk_start(); clk_end();
        chk("t1_mem_req", 64'(mem_req), 64'd1);
        chk("t1_mem_addr", 64'(mem_addr), 64'h40);
        chk("t1_I_ack", 64'(I_ack), 64'd1);
        chk("t1_I_rdata", 64'(I_rdata), 64'hE3A01005);
        clk_start(); I_req = 1'b0; clk_end();
        chk("t1_busy_after", 64'(busy), 64'd0);

        // Simultaneous requests: D priority then starvation guard
        grant_log.delete();
        streak_at_igrant = -1;
        clk_start();
        mem_wait = 1;
        I_req = 1'b1; I_addr = 32'h80;
        D_req = 1'b1; D_we = 1'b0; D_addr = 32'h10;
        clk_end();
        for (int k = 0; k < 18; k++) begin
            clk_start();
            if (seen_iack) I_req = 1'b0;
            clk_end();
        end
        clk_start(); D_req = 1'b0; I_req = 1'b0; clk_end();
        idle_cycles(4);
        chk("t2_log_len", 64'(grant_log.size() >= 6), 64'd1);
        if (grant_log.size() >= 6) begin
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("t2_grant%0d", k), 64'(grant_log[k]), 64'(exp_seq[k]));
            end
        end
        chk("t2_streak_at_i", 64'(streak_at_igrant), 64'd4);

        // Store with 3 wait cycles, then read it back
        clk_start();
        mem_wait = 3;
        D_req = 1'b1; D_we = 1'b1; D_addr = 32'h100; D_wdata = 32'hDEADBEEF;
        clk_end();
        for (int k = 1; k <= 4; k++) begin
            clk_start(); clk_end();
            chk($sformatf("t3_we%0d", k), 64'(mem_we), 64'd1);
            chk($sformatf("t3_wdata%0d", k), 64'(mem_wdata), 64'hDEADBEEF);
            chk($sformatf("t3_D_ack%0d", k), 64'(D_ack), 64'(k == 4));
        end
        clk_start(); D_req = 1'b0; D_we = 1'b0; clk_end();
        chk("t3_idle", 64'(busy), 64'd0);
        clk_start(); mem_wait = 0; D_req = 1'b1; D_addr = 32'h100; clk_end();
        clk_start(); clk_end();
        chk("t3_load_ack", 64'(D_ack), 64'd1);
        chk("t3_load_data", 64'(D_rdata), 64'hDEADBEEF);
        clk_start(); D_req = 1'b0; clk_end();

        // Mispredict during fetch, D pending throughout the drop
        clk_start(); mem_wait = 3; I_req = 1'b1; I_addr = 32'h20; clk_end();
        clk_start();
        I_cancel = 1'b1;
        D_req = 1'b1; D_we = 1'b0; D_addr = 32'h30;
        clk_end();
        chk("t4_state_busy_i", 64'(state_dbg), 64'd1);
        for (int k = 2; k <= 4; k++) begin
            clk_start(); I_cancel = (k == 3); I_req = 1'b0; clk_end();
            chk($sformatf("t4_state%0d", k), 64'(state_dbg), 64'd3);
            chk($sformatf("t4_mem_req%0d", k), 64'(mem_req), 64'd1);
            chk($sformatf("t4_mem_addr%0d", k), 64'(mem_addr), 64'h20);
            chk($sformatf("t4_I_ack%0d", k), 64'(I_ack), 64'd0);
        end
        clk_start(); I_cancel = 1'b0; clk_end();
        chk("t4_idle", 64'(busy), 64'd0);
        clk_start(); clk_end();
        chk("t4_d_state", 64'(state_dbg), 64'd2);
        chk("t4_d_addr", 64'(mem_addr), 64'h30);
        clk_start(); D_req = 1'b0; clk_end();
        idle_cycles(5);

        // Cancel coincident with ack; cancelled request in IDLE
        clk_start(); mem_wait = 1; I_req = 1'b1; I_addr = 32'h44; clk_end();
        clk_start(); clk_end();
        clk_start(); I_cancel = 1'b1; clk_end();
        chk("t5_I_ack", 64'(I_ack), 64'd0);
        clk_start(); I_cancel = 1'b0; I_req = 1'b0; clk_end();
        chk("t5_idle", 64'(busy), 64'd0);
        clk_start(); I_req = 1'b1; I_cancel = 1'b1; clk_end();
        clk_start(); I_req = 1'b0; I_cancel = 1'b0; clk_end();
        chk("t5_no_grant", 64'(busy), 64'd0);

        // Reset during a BUSY_D wait
        clk_start();
        mem_wait = 3;
        D_req = 1'b1; D_we = 1'b0; D_addr = 32'h8;
        I_req = 1'b1; I_addr = 32'h4;
        clk_end();
        clk_start(); clk_end();
        chk("t6_streak_pre", 64'(streak_dbg), 64'd1);
        clk_start(); Reset = 1'b0; clk_end();
        clk_start(); Reset = 1'b1; D_req = 1'b0; clk_end();
        chk("t6_mem_req", 64'(mem_req), 64'd0);
        chk("t6_D_ack", 64'(D_ack), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_streak", 64'(streak_dbg), 64'd0);
        clk_start(); clk_end();
        chk("t6_regrant_state", 64'(state_dbg), 64'd1);
        chk("t6_regrant_addr", 64'(mem_addr), 64'h4);
        for (int k = 0; k < 4; k++) begin
            clk_start();
            if (seen_iack) I_req = 1'b0;
            clk_end();
        end
        idle_cycles(2);

        // Random traffic
        rand_wait = 1'b1;
        mem_wait  = int'($urandom_range(0, 3));
        i_pend    = 1'b0;
        d_pend    = 1'b0;
        n_acks    = 0;
        for (int c = 0; c < 3000; c++) begin
            clk_start();
            if ($urandom_range(0, 299) == 0) begin
                Reset  = 1'b0;
                i_pend = 1'b0;
                d_pend = 1'b0;
            end else begin
                Reset = 1'b1;
                if (d_pend && seen_dack) d_pend = 1'b0;
                if (!d_pend && $urandom_range(0, 2) == 0) begin
                    d_pend  = 1'b1;
                    D_we    = 1'($urandom_range(0, 1));
                    D_addr  = 32'($urandom_range(0, 63)) << 2;
                    D_wdata = $urandom;
                end
                if (i_pend && (seen_iack || seen_icancel)) i_pend = 1'b0;
                if (!i_pend && $urandom_range(0, 1) == 0) begin
                    i_pend = 1'b1;
                    I_addr = 32'($urandom_range(0, 63)) << 2;
                end
            end
            D_req    = d_pend;
            I_req    = i_pend;
            I_cancel = Reset && ($urandom_range(0, 7) == 0);
            clk_end();
        end
        clk_start(); Reset = 1'b1; I_req = 1'b0; D_req = 1'b0; I_cancel = 1'b0; clk_end();
        idle_cycles(6);
        chk("rand_activity", 64'(n_acks > 300), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
